// File: rtl/card_dealer.sv
// Card dealer: reduces a free-running seed modulo 13 and draws one card from a finite shoe.
// Optional macro DEALER_AUTO_RESHUFFLE_EN: an empty-shoe request refills the shoe and deals instead of rejecting.
module card_dealer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DECKS = 1
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Seed,
  input  logic             i_Req,
  input  logic             i_Shuffle,
  output logic             o_Valid,
  output logic             o_Reject,
  output logic [3:0]       o_Rank,
  output logic [3:0]       o_Value,
  output logic [7:0]       o_CardsLeft,
  output logic             o_DeckEmpty,
  output logic             o_Busy
);

  localparam int unsigned NRANK = 13;
  localparam int unsigned LIMIT = 4 * DECKS;
  localparam int unsigned CW    = $clog2(LIMIT + 1);
  localparam int unsigned FULL  = 52 * DECKS;
`ifdef DEALER_AUTO_RESHUFFLE_EN
  localparam bit AUTO_RESHUFFLE = 1'b1;
`else
  localparam bit AUTO_RESHUFFLE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SHUFFLE, REDUCE, PROBE, DONE} state_t;

  state_t                    state_q, state_nx;
  logic [WIDTH-1:0]          mod_q, mod_nx;
  logic [3:0]                idx_q, idx_nx;
  logic                      auto_q, auto_nx;
  logic [NRANK-1:0][CW-1:0]  counts_q;
  logic                      clr_counts, inc_count;
  logic [3:0]                rank_nx, value_nx;
  logic [7:0]                left_nx;
  logic                      valid_nx, reject_nx;

  // Blackjack value of a zero-based rank index
  function automatic logic [3:0] card_value(input logic [3:0] idx);
    if (idx == 4'd0)       return 4'd11;
    else if (idx >= 4'd10) return 4'd10;
    else                   return idx + 4'd1;
  endfunction

  assign o_DeckEmpty = (o_CardsLeft == 8'd0);
  assign o_Busy      = (state_q != IDLE);

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      mod_q       <= '0;
      idx_q       <= '0;
      auto_q      <= 1'b0;
      counts_q    <= '0;
      o_Rank      <= '0;
      o_Value     <= '0;
      o_CardsLeft <= 8'(FULL);
      o_Valid     <= 1'b0;
      o_Reject    <= 1'b0;
    end else begin
      state_q     <= state_nx;
      mod_q       <= mod_nx;
      idx_q       <= idx_nx;
      auto_q      <= auto_nx;
      o_Rank      <= rank_nx;
      o_Value     <= value_nx;
      o_CardsLeft <= left_nx;
      o_Valid     <= valid_nx;
      o_Reject    <= reject_nx;
      if (clr_counts)     counts_q <= '0;
      else if (inc_count) counts_q[idx_q] <= counts_q[idx_q] + CW'(1);
    end
  end

  always_comb begin
    state_nx   = state_q;
    mod_nx     = mod_q;
    idx_nx     = idx_q;
    auto_nx    = auto_q;
    rank_nx    = o_Rank;
    value_nx   = o_Value;
    left_nx    = o_CardsLeft;
    valid_nx   = 1'b0;
    reject_nx  = 1'b0;
    clr_counts = 1'b0;
    inc_count  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Shuffle) begin
          state_nx = SHUFFLE;
        end else if (i_Req) begin
          if (o_DeckEmpty && !AUTO_RESHUFFLE) begin
            state_nx  = DONE;
            reject_nx = 1'b1;
          end else begin
            mod_nx   = i_Seed;
            auto_nx  = o_DeckEmpty;
            state_nx = o_DeckEmpty ? SHUFFLE : REDUCE;
          end
        end
      end
      // A shuffle launched by an empty-shoe request continues straight into the deal
      SHUFFLE: begin
        clr_counts = 1'b1;
        left_nx    = 8'(FULL);
        auto_nx    = 1'b0;
        state_nx   = auto_q ? REDUCE : IDLE;
      end
      REDUCE: begin
        if (mod_q >= WIDTH'(NRANK)) begin
          mod_nx = mod_q - WIDTH'(NRANK);
        end else begin
          idx_nx   = 4'(mod_q);
          state_nx = PROBE;
        end
      end
      PROBE: begin
        if (counts_q[idx_q] < CW'(LIMIT)) begin
          inc_count = 1'b1;
          left_nx   = o_CardsLeft - 8'd1;
          rank_nx   = idx_q + 4'd1;
          value_nx  = card_value(idx_q);
          valid_nx  = 1'b1;
          state_nx  = DONE;
        end else begin
          idx_nx = (idx_q == 4'd12) ? 4'd0 : idx_q + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: shoe model with per-rank counts, random seeds, directed corner cases.
module tb_card_dealer;
  localparam int unsigned WIDTH = 12;

  logic             clk_50M = 1'b0;
  logic             i_Reset;
  logic [WIDTH-1:0] i_Seed;
  logic             i_Req;
  logic             i_Shuffle;
  logic             o_Valid, o_Reject, o_DeckEmpty, o_Busy;
  logic [3:0]       o_Rank, o_Value;
  logic [7:0]       o_CardsLeft;

  card_dealer #(.WIDTH(WIDTH), .DECKS(1)) dut (
    .clk_50M(clk_50M), .i_Reset(i_Reset), .i_Seed(i_Seed), .i_Req(i_Req),
    .i_Shuffle(i_Shuffle), .o_Valid(o_Valid), .o_Reject(o_Reject), .o_Rank(o_Rank),
    .o_Value(o_Value), .o_CardsLeft(o_CardsLeft), .o_DeckEmpty(o_DeckEmpty), .o_Busy(o_Busy)
  );

  always #10 clk_50M = ~clk_50M;

  int n_cmp = 0;
  int n_err = 0;

  // Shoe model: cards dealt per rank (0-based), cards left, last dealt rank (1-based, 0 = none)
  int m_count [13];
  int m_left;
  int m_rank;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int val_of(input int rank);
    if (rank == 0)       return 0;
    else if (rank == 1)  return 11;
    else if (rank >= 11) return 10;
    else                 return rank;
  endfunction

  task automatic model_shuffle();
    for (int i = 0; i < 13; i++) m_count[i] = 0;
    m_left = 52;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_valid"}, o_Valid, 0);
    check({tag, "_reject"}, o_Reject, 0);
    check({tag, "_busy"}, o_Busy, 0);
    check({tag, "_left"}, o_CardsLeft, m_left);
    check({tag, "_empty"}, o_DeckEmpty, (m_left == 0) ? 1 : 0);
    check({tag, "_rank"}, o_Rank, m_rank);
    check({tag, "_value"}, o_Value, val_of(m_rank));
  endtask

  task automatic do_reset();
    @(negedge clk_50M);
    i_Reset = 1'b1; i_Req = 1'b0; i_Shuffle = 1'b0;
    @(negedge clk_50M);
    i_Reset = 1'b0;
    model_shuffle();
    m_rank = 0;
    check_idle_state("reset");
  endtask

  task automatic do_shuffle();
    @(negedge clk_50M);
    i_Shuffle = 1'b1;
    @(negedge clk_50M);
    i_Shuffle = 1'b0;
    check("shuffle_busy", o_Busy, 1);
    @(negedge clk_50M);
    model_shuffle();
    check_idle_state("shuffle");
  endtask

  // One request/response transaction; the model predicts card, latency and pulse kind
  task automatic deal(input int seed, output int got_rank, output int got_lat, output int got_rej);
    int r, skip, lat, rej, autoshuf;
    rej = 0; autoshuf = 0; r = 0; skip = 0;
    if (m_left == 0) begin
`ifdef DEALER_AUTO_RESHUFFLE_EN
      autoshuf = 1;
      model_shuffle();
`else
      rej = 1;
`endif
    end
    if (rej == 0) begin
      r = seed % 13;
      while (m_count[r] >= 4) begin
        r = (r + 1) % 13;
        skip++;
      end
      lat = 3 + seed / 13 + skip + autoshuf;
    end else begin
      lat = 1;
    end

    @(negedge clk_50M);
    i_Seed = WIDTH'(seed);
    i_Req  = 1'b1;
    got_lat = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_50M);
      if (k == 1) i_Seed = WIDTH'($urandom);
      if (o_Valid || o_Reject) begin
        got_lat = k;
        break;
      end
      check("busy_while_dealing", o_Busy, 1);
    end
    i_Req = 1'b0;
    check("latency", got_lat, lat);
    check("valid_pulse", o_Valid, (rej == 0) ? 1 : 0);
    check("reject_pulse", o_Reject, rej);
    if (rej == 0) begin
      m_count[r]++;
      m_left--;
      m_rank = r + 1;
    end
    check("rank", o_Rank, m_rank);
    check("value", o_Value, val_of(m_rank));
    check("cards_left", o_CardsLeft, m_left);
    check("deck_empty", o_DeckEmpty, (m_left == 0) ? 1 : 0);
    got_rank = o_Rank;
    got_rej  = o_Reject;
    @(negedge clk_50M);
    check("pulse_width", o_Valid | o_Reject, 0);
    check("idle_after_done", o_Busy, 0);
  endtask

  initial begin
    int rk, lt, rj, lt4;
    i_Reset = 1'b1; i_Req = 1'b0; i_Shuffle = 1'b0; i_Seed = '0;
    m_rank = 0;
    model_shuffle();
    repeat (2) @(negedge clk_50M);
    do_reset();

    // Hand-computed literals pin the model as well as the DUT
    deal(0, rk, lt, rj);
    check("lit_seed0_rank", rk, 1);
    check("lit_seed0_lat", lt, 3);
    check("lit_seed0_value", o_Value, 11);
    check("lit_seed0_left", o_CardsLeft, 51);
    deal(25, rk, lt, rj);
    check("lit_seed25_rank", rk, 13);
    check("lit_seed25_lat", lt, 4);

    lt4 = 0;
    for (int i = 0; i < 4; i++) begin
      deal(4, rk, lt, rj);
      check("lit_seed4_rank", rk, 5);
      lt4 = lt;
    end
    deal(4, rk, lt, rj);
    check("lit_seed4_skip_rank", rk, 6);
    check("lit_seed4_skip_lat", lt, lt4 + 1);

    do_reset();
    for (int i = 0; i < 4; i++) deal(12, rk, lt, rj);
    deal(12, rk, lt, rj);
    check("lit_wrap_rank", rk, 1);
    check("lit_wrap_value", o_Value, 11);

    // Drain the shoe with random seeds, then request from the empty shoe
    for (int g = 0; g < 60 && m_left > 0; g++) deal(int'($urandom_range(0, 4095)), rk, lt, rj);
    check("lit_drained_left", o_CardsLeft, 0);
    check("lit_drained_empty", o_DeckEmpty, 1);
    deal(int'($urandom_range(0, 4095)), rk, lt, rj);
`ifdef DEALER_AUTO_RESHUFFLE_EN
    check("lit_auto_reject", rj, 0);
    check("lit_auto_left", o_CardsLeft, 51);
`else
    check("lit_empty_reject", rj, 1);
    check("lit_empty_left", o_CardsLeft, 0);
`endif
    do_shuffle();
    check("lit_shuffle_left", o_CardsLeft, 52);
    check("lit_shuffle_empty", o_DeckEmpty, 0);

    // Reset while REDUCE is grinding through a large seed
    deal(7, rk, lt, rj);
    @(negedge clk_50M);
    i_Seed = WIDTH'(4095);
    i_Req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_50M);
      check("abort_no_valid", o_Valid, 0);
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_50M);
      check("post_reset_no_valid", o_Valid, 0);
    end
    check("lit_abort_left", o_CardsLeft, 52);
    deal(0, rk, lt, rj);
    check("lit_abort_ace", rk, 1);

    // Random mix of deals and occasional shuffles
    for (int g = 0; g < 40; g++) begin
      if ($urandom_range(0, 7) == 0) do_shuffle();
      deal(int'($urandom_range(0, 4095)), rk, lt, rj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Downstream consumer of the free-running 12-bit game counter; uses its value as a pseudo-random seed to draw one card from a finite shoe.
- Reduces the seed modulo 13 to a rank and tracks how many cards of each rank have been dealt.
- Skips exhausted ranks with a linear probe.
- Returns rank and blackjack value to the game FSM over a request/valid handshake.

Parameters:
- WIDTH, 12, width of i_Seed; matches the counter output width.
- DECKS, 1, number of 52-card decks in the shoe (1..4); per-rank limit = 4*DECKS.

Ports:
- clk_50M  input  1  50 MHz system clock
- i_Reset  input  1  reset (sync, active-high)
- i_Seed  input  WIDTH  counter value used as random seed
- i_Req  input  1  level request; held until o_Valid or o_Reject
- i_Shuffle  input  1  refill shoe (honoured only in IDLE)
- o_Valid  output  1  one-cycle pulse; o_Rank/o_Value valid
- o_Reject  output  1  one-cycle pulse; request refused, shoe empty
- o_Rank  output  4  1=Ace .. 13=King, held until next deal
- o_Value  output  4  Ace=11, 2..10=rank, J/Q/K=10
- o_CardsLeft  output  8  cards remaining in shoe
- o_DeckEmpty  output  1  o_CardsLeft==0
- o_Busy  output  1  state != IDLE

Behaviour:
- Reset (i_Reset sampled on clk_50M):
  - State IDLE; all 13 rank counts 0; o_CardsLeft = 52*DECKS.
  - o_Rank=0, o_Value=0, o_Valid=0, o_Reject=0, o_DeckEmpty=0.
  - Reset mid-operation aborts the deal: no o_Valid, counts cleared.
- States: IDLE, SHUFFLE, REDUCE, PROBE, DONE.
- IDLE, evaluated in priority order:
  - i_Shuffle -> SHUFFLE. Any simultaneous i_Req is not accepted and remains pending.
  - i_Req with shoe empty -> DONE with o_Reject.
  - i_Req otherwise -> latch i_Seed into r_Mod, go REDUCE.
- SHUFFLE: clear counts, o_CardsLeft=52*DECKS, -> IDLE. Takes 1 cycle.
- REDUCE:
  - If r_Mod >= 13: r_Mod <= r_Mod - 13, stay.
  - Else: r_Idx <= r_Mod, -> PROBE.
  - Cycles in REDUCE = floor(seed/13)+1; worst case 316 for WIDTH=12.
- PROBE:
  - If count[r_Idx] < 4*DECKS: increment count[r_Idx], decrement o_CardsLeft, o_Rank <= r_Idx+1, o_Value <= mapped value, -> DONE with o_Valid.
  - Else: r_Idx <= (r_Idx==12) ? 0 : r_Idx+1, stay.
  - At most 13 cycles; termination guaranteed because the shoe is non-empty on entry.
- DONE:
  - o_Valid or o_Reject is high for exactly this cycle.
  - i_Req is ignored; unconditional -> IDLE.
  - Requester must drop i_Req on seeing the pulse.
- Latency from the accepting IDLE edge to o_Valid high: 3 + floor(seed/13) + skipped probes.
- i_Shuffle outside IDLE is ignored.
- i_Seed is sampled only at acceptance; later changes have no effect.
- o_DeckEmpty and o_Busy are combinational from registers.

Optional Feature:
- Macro DEALER_AUTO_RESHUFFLE_EN.
- Defined: i_Req in IDLE with shoe empty latches the seed, runs one SHUFFLE cycle, then proceeds to REDUCE. The card is dealt from the fresh shoe, latency +1 cycle, and o_Reject is never asserted.
- Undefined: empty-shoe request produces an o_Reject pulse one cycle after acceptance; shoe unchanged.

Test Plan:
- Reset, i_Seed=0, i_Req -> o_Valid 3 cycles after acceptance edge; o_Rank=1, o_Value=11, o_CardsLeft=51.
- i_Seed=25 -> o_Rank=13, o_Value=10, latency 4.
- Four deals with i_Seed=4 (rank 5, value 5), then a fifth with i_Seed=4 -> o_Rank=6, latency +1 vs fourth.
- Exhaust rank 13 (i_Seed=12 x4), then i_Seed=12 -> probe wraps, o_Rank=1, o_Value=11.
- Deal 52 cards, then:
  - 53rd request -> o_DeckEmpty=1 and o_Reject pulse for 1 cycle, no o_Valid (macro undefined).
  - Same with macro defined -> o_Valid, o_CardsLeft=51.
  - i_Shuffle in IDLE -> o_CardsLeft=52, o_DeckEmpty=0.
- i_Seed=4095, assert i_Reset during REDUCE -> no o_Valid; o_CardsLeft=52; next request with i_Seed=0 deals Ace.
